// File: rtl/des_block_packer.sv
// Packs an 8-bit byte stream into 64-bit DES blocks (bit 1 = MSB), padding a short final block.
// Latency: last byte at edge N -> m_valid from N+1; a second block waits in asm_q and stalls s_ready.
module des_block_packer #(
  parameter logic [7:0] PAD_BYTE  = 8'h00,
  parameter bit         MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        s_last,
  output logic [1:64] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_padded
);

  logic [2:0]  cnt_q;
  logic [63:0] asm_q;
  logic        pad_q;
  logic        pending_q;
  logic [63:0] out_q;
  logic        out_pad_q;
  logic        vld_q;

  logic [63:0] blk;
  logic        accept;
  logic        complete;
  logic        out_free;
  logic        blk_padded;

  // Bit offset (in a [63:0] view) of the low bit of byte slot k.
  function automatic int slot_lo(input int k);
    return MSB_FIRST ? (56 - 8 * k) : (8 * k);
  endfunction

  assign s_ready    = !rst && !pending_q;
  assign accept     = s_valid && s_ready;
  assign complete   = accept && ((cnt_q == 3'd7) || s_last);
  assign out_free   = !vld_q || m_ready;
  assign blk_padded = s_last && (cnt_q != 3'd7);

  // Current assembly with the incoming byte merged and, on s_last, the tail padded.
  always_comb begin
    blk = asm_q;
    blk[slot_lo(int'(cnt_q)) +: 8] = s_data;
    if (s_last) begin
      for (int k = 0; k < 8; k++) begin
        if (k > int'(cnt_q)) blk[slot_lo(k) +: 8] = PAD_BYTE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 3'd0;
      asm_q     <= 64'd0;
      pad_q     <= 1'b0;
      pending_q <= 1'b0;
      out_q     <= 64'd0;
      out_pad_q <= 1'b0;
      vld_q     <= 1'b0;
    end else begin
      if (vld_q && m_ready) vld_q <= 1'b0;

      if (pending_q && out_free) begin
        out_q     <= asm_q;
        out_pad_q <= pad_q;
        vld_q     <= 1'b1;
        pending_q <= 1'b0;
      end

      // accept implies !pending_q, so this never collides with the move above.
      if (accept) begin
        if (complete) begin
          cnt_q <= 3'd0;
          if (out_free) begin
            out_q     <= blk;
            out_pad_q <= blk_padded;
            vld_q     <= 1'b1;
          end else begin
            asm_q     <= blk;
            pad_q     <= blk_padded;
            pending_q <= 1'b1;
          end
        end else begin
          asm_q <= blk;
          cnt_q <= cnt_q + 3'd1;
        end
      end
    end
  end

  assign m_data   = out_q;
  assign m_valid  = vld_q;
  assign m_padded = out_pad_q;

endmodule
